systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Operand feeder and sequencer for the N×N systolic PE array. It accepts one k-step of operands per handshake beat: one column of A and one row of B. It applies the diagonal skew the array needs, so that a[i][k] and b[k][j] meet in PE(i,j), and drives the array-wide enable. After the last beat it drains the PE pipelines and pulses `done`, at which point every PE `c_out` holds its finished dot product.

## Interface
Parameters:
- `data_width`, 8: operand width; must match the PE array.
- `N`, 2: array dimension (rows = columns = lanes).
- `K_MAX`, 16: maximum reduction length.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a job; sampled only in IDLE.
- `k_len`  in  $clog2(K_MAX+1): number of k-beats; sampled with `start`.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: feeder accepts a beat.
- `in_a`  in  N*data_width: A column; lane i occupies bits [i*data_width +: data_width] and carries A[i][k].
- `in_b`  in  N*data_width: B row; lane j carries B[k][j].
- `a_edge`  out  N*data_width: left edge; lane i drives `a_in` of PE(i,0).
- `b_edge`  out  N*data_width: top edge; lane j drives `b_in` of PE(0,j).
- `pe_en`  out  1: enable to every PE.
- `array_clr`  out  1: one-cycle registered pulse, ORed into the array reset.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse; results are valid.
- `stall_cnt`  out  16: feed-stall counter (see Configuration).

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: if `start` is high, latch `k_len`, zero the beat counter, and go to CLEAR.
  - `start` is ignored in every other state.
- CLEAR, one cycle: `array_clr`=1, `pe_en`=0, and all skew registers are cleared.
  - `k_len`=0: go to DONE.
  - Otherwise: go to FEED.
- FEED:
  - `in_ready`=1.
  - Beat accepted when `in_valid && in_ready`.
  - `pe_en` = accept, combinational from the `in_valid` AND state decode.
  - The skew lines advance only when `pe_en`=1, so a stall freezes the array and the feeder together and preserves alignment.
  - After beat `k_len`, go to DRAIN.
- DRAIN:
  - `in_ready`=0 and `pe_en`=1 for exactly DRAIN_LEN = 4*(N-1)+4 cycles.
  - Zeros are injected at the skew inputs.
  - Then go to DONE.
- DONE, one cycle: `done`=1, `pe_en`=0; then go to IDLE.
- Skew: the PE forwards operands with 2-cycle hop latency.
  - Lane i of `a_edge` and lane j of `b_edge` are delayed 2i and 2j en-cycles respectively.
  - Each delay sits behind one output register stage common to all lanes.
  - Lane 0 has no delay beyond that output stage.
- Edge outputs are fully registered.
  - When `pe_en`=0 they hold their value.
  - Held values are harmless because the array is frozen.
- Arithmetic:
  - No operand arithmetic is performed.
  - The beat counter is $clog2(K_MAX+1) bits.
  - The drain counter is sized for DRAIN_LEN.
  - `k_len` > K_MAX is clamped to K_MAX.

## Timing
- Reset values: `in_ready`=0, `a_edge`=0, `b_edge`=0, `pe_en`=0, `array_clr`=0, `busy`=0, `done`=0, `stall_cnt`=0; state = IDLE.
- `rst` mid-job: everything returns to IDLE immediately. No `done` is issued and the partial job is discarded.
- Job length with no stalls: `start` at cycle t gives `done` at t + 2 + k_len + DRAIN_LEN.
  - For N=2, k_len=2 this is t+12.
- Each stall cycle in FEED adds exactly one cycle to the job length.
- A beat accepted at cycle c appears on lane 0 of the edges at c+1, and on lane i at c+1+2i en-cycles.
- `start` held high through DONE does not restart a job until IDLE is re-entered. A new job therefore starts at the earliest one cycle after `done`.

## Configuration
- Macro: `SYSTOLIC_FEEDER_STALL_CNT_EN`.
- Defined: `stall_cnt` increments on each FEED cycle with `in_valid`=0, saturates at 16'hFFFF, and clears in CLEAR.
- Undefined: the counter logic is compiled out and `stall_cnt` is tied to 0.

## Test plan
- Reset: assert `rst` mid-FEED → all outputs 0, `busy`=0 within the same cycle; no `done`.
- 2×2 matmul, N=2, `k_len`=2:
  - Beat0: `in_a`={3,1}, `in_b`={6,5}.
  - Beat1: `in_a`={4,2}, `in_b`={8,7}.
  - Expect PE `c_out` = [[19,22],[43,50]] at `done`, with `done` at start+12.
- Stall: same job with `in_valid` low for 3 cycles between beats → identical results, `done` at start+15, and `stall_cnt`=3 with the macro (0 without).
- Timing of skew: a single beat with lane values {0xAA,0x55} → lane 0 shows 0x55 one cycle after accept; lane 1 shows 0xAA two en-cycles later.
- Boundaries:
  - `k_len`=0 → `array_clr` pulse, no `pe_en`, `done` at start+2.
  - `k_len`=K_MAX back-to-back with `start` held high → second job starts one cycle after `done`.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Operand stream into the systolic feeder: one A column and one B row per valid/ready beat.
interface systolic_feeder_if #(
  parameter int data_width = 8,
  parameter int N = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*data_width-1:0] in_a;
  logic [N*data_width-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Skews operand beats onto the N x N array edges (lane i delayed 2i en-cycles, beat at c on lane 0 at c+1); a stall freezes feeder and array together.
// SYSTOLIC_FEEDER_STALL_CNT_EN compiles in a saturating count of FEED cycles without in_valid.
module systolic_feeder #(
  parameter int data_width = 8,
  parameter int N = 2,
  parameter int K_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  systolic_feeder_if.slave             op,
  output logic [N*data_width-1:0]      a_edge,
  output logic [N*data_width-1:0]      b_edge,
  output logic                         pe_en,
  output logic                         array_clr,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  stall_cnt
);
  localparam int KW = $clog2(K_MAX+1);
  localparam int DRAIN_LEN = 4*(N-1) + 4;
  localparam int DCW = $clog2(DRAIN_LEN+1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic [KW-1:0]  k_lim;
  logic [KW-1:0]  k_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [KW-1:0]  k_clamped;
  logic           feeding;
  logic           accept;
  logic           last_beat;

  assign k_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign feeding   = (state == S_FEED);
  assign accept    = feeding && op.in_valid;
  assign pe_en     = accept || (state == S_DRAIN);
  assign last_beat = (k_cnt == k_lim - KW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      k_lim       <= '0;
      k_cnt       <= '0;
      drain_cnt   <= '0;
      op.in_ready <= 1'b0;
      array_clr   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            k_lim     <= k_clamped;
            k_cnt     <= '0;
            array_clr <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_CLEAR: begin
          array_clr <= 1'b0;
          if (k_lim == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state       <= S_FEED;
            op.in_ready <= 1'b1;
          end
        end
        S_FEED: begin
          if (op.in_valid) begin
            k_cnt <= k_cnt + KW'(1);
            if (last_beat) begin
              state       <= S_DRAIN;
              op.in_ready <= 1'b0;
              drain_cnt   <= '0;
            end
          end
        end
        S_DRAIN: begin
          // Long enough for the last beat to cross the far corner PE.
          if (drain_cnt == DCW'(DRAIN_LEN-1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int DEPTH = 2*i + 1;
    logic [data_width-1:0] a_sr [DEPTH];
    logic [data_width-1:0] b_sr [DEPTH];
    logic [data_width-1:0] a_inj;
    logic [data_width-1:0] b_inj;

    // Outside an accepted beat (DRAIN) zeros are shifted in.
    assign a_inj = accept ? op.in_a[i*data_width +: data_width] : '0;
    assign b_inj = accept ? op.in_b[i*data_width +: data_width] : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < DEPTH; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else if (state == S_CLEAR) begin
        for (int s = 0; s < DEPTH; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else if (pe_en) begin
        a_sr[0] <= a_inj;
        b_sr[0] <= b_inj;
        for (int s = 1; s < DEPTH; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign a_edge[i*data_width +: data_width] = a_sr[DEPTH-1];
    assign b_edge[i*data_width +: data_width] = b_sr[DEPTH-1];
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == S_CLEAR) begin
      stall_q <= '0;
    end else if (feeding && !op.in_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: queue-based edge model, per-cycle compare, and an array dot-product model fed from the DUT edges.
`timescale 1ns/1ps
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N = 2;
  localparam int K_MAX = 16;
  localparam int KW = $clog2(K_MAX+1);
  localparam int DRAIN_LEN = 4*(N-1) + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic [N*DW-1:0] a_edge, b_edge;
  logic          pe_en, array_clr, busy, done;
  logic [15:0]   stall_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  systolic_feeder_if #(.data_width(DW), .N(N)) op();

  systolic_feeder #(.data_width(DW), .N(N), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .op(op.slave),
    .a_edge(a_edge), .b_edge(b_edge), .pe_en(pe_en), .array_clr(array_clr),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: job phases plus the sequence of values pushed into the skew lines.
  typedef enum int {M_IDLE, M_CLR, M_FEED, M_DRAIN, M_FIN} mphase_t;
  mphase_t ph = M_IDLE;
  int m_k = 0, m_beats = 0, m_drain = 0, m_stalls = 0;
  logic [N*DW-1:0] pa[$];
  logic [N*DW-1:0] pb[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = M_IDLE;
      pa.delete();
      pb.delete();
      m_stalls = 0;
    end else begin
      case (ph)
        M_IDLE: if (start) begin
          m_k = (int'(k_len) > K_MAX) ? K_MAX : int'(k_len);
          m_beats = 0;
          ph = M_CLR;
        end
        M_CLR: begin
          pa.delete();
          pb.delete();
          m_stalls = 0;
          ph = (m_k == 0) ? M_FIN : M_FEED;
        end
        M_FEED: begin
          if (op.in_valid) begin
            pa.push_back(op.in_a);
            pb.push_back(op.in_b);
            m_beats++;
            if (m_beats == m_k) begin
              ph = M_DRAIN;
              m_drain = DRAIN_LEN;
            end
          end else if (m_stalls < 65535) begin
            m_stalls++;
          end
        end
        M_DRAIN: begin
          pa.push_back('0);
          pb.push_back('0);
          m_drain--;
          if (m_drain == 0) ph = M_FIN;
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  // Edge samples of every enabled cycle, and the dot products an array would form from them.
  logic [N*DW-1:0] sa[$];
  logic [N*DW-1:0] sb[$];
  int cm[N][N];

  function automatic int lane(input logic [N*DW-1:0] v, input int i);
    return int'(v[i*DW +: DW]);
  endfunction

  always @(negedge clk) begin
    logic [N*DW-1:0] ea_x, eb_x, ta, tb;
    logic [4:0]  ctrl_x;
    logic [15:0] stall_x;
    logic        en_x;
    int          s;
    ea_x = '0;
    eb_x = '0;
    for (int i = 0; i < N; i++) begin
      if (pa.size() > 2*i) begin
        ta = pa[pa.size()-1-2*i];
        tb = pb[pb.size()-1-2*i];
        ea_x[i*DW +: DW] = ta[i*DW +: DW];
        eb_x[i*DW +: DW] = tb[i*DW +: DW];
      end
    end
    en_x = ((ph == M_FEED) && op.in_valid) || (ph == M_DRAIN);
    ctrl_x = {ph == M_FEED, en_x, ph == M_CLR, ph != M_IDLE, ph == M_FIN};
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    stall_x = 16'(m_stalls);
`else
    stall_x = 16'd0;
`endif
    check("ctrl", 64'({op.in_ready, pe_en, array_clr, busy, done}), 64'(ctrl_x));
    check("a_edge", 64'(a_edge), 64'(ea_x));
    check("b_edge", 64'(b_edge), 64'(eb_x));
    check("stall_cnt", 64'(stall_cnt), 64'(stall_x));

    if (array_clr) begin
      sa.delete();
      sb.delete();
    end
    if (pe_en) begin
      sa.push_back(a_edge);
      sb.push_back(b_edge);
    end
    // PE(i,j) sees the left edge 2j en-cycles late and the top edge 2i en-cycles late.
    if (done) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          s = 0;
          for (int m = 0; m < sa.size(); m++) begin
            if (m - 2*j >= 0 && m - 2*i >= 0)
              s += lane(sa[m-2*j], i) * lane(sb[m-2*i], j);
          end
          cm[i][j] = s;
        end
      end
    end
  end

  task automatic start_job(input int k, output int t0);
    @(posedge clk); #1;
    k_len = KW'(k);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input int stall);
    op.in_valid = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
    end
    op.in_valid = 1'b1;
    op.in_a = a;
    op.in_b = b;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (op.in_ready) break;
    end
    check("beat_ready", 64'(op.in_ready), 64'd1);
    @(posedge clk); #1;
    op.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int td);
    td = -1;
    for (int w = 0; w < budget; w++) begin
      @(negedge clk); #2;
      if (done) begin
        td = cyc;
        break;
      end
    end
    check("done_seen", 64'(td >= 0), 64'd1);
  endtask

  task automatic check_c(input string tag, input int c00, input int c01, input int c10, input int c11);
    check({tag, "_c00"}, 64'(cm[0][0]), 64'(c00));
    check({tag, "_c01"}, 64'(cm[0][1]), 64'(c01));
    check({tag, "_c10"}, 64'(cm[1][0]), 64'(c10));
    check({tag, "_c11"}, 64'(cm[1][1]), 64'(c11));
  endtask

  initial begin
    int t0, td, td2, nd;
    op.in_valid = 1'b0;
    op.in_a = '0;
    op.in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({op.in_ready, pe_en, array_clr, busy, done, a_edge, b_edge, stall_cnt}), 64'd0);
    rst = 1'b0;

    // 2x2 matmul, no stalls
    start_job(2, t0);
    send_beat({8'd3, 8'd1}, {8'd6, 8'd5}, 0);
    send_beat({8'd4, 8'd2}, {8'd8, 8'd7}, 0);
    wait_done(100, td);
    check("mm_latency", 64'(td - t0), 64'd12);
    check_c("mm", 19, 22, 43, 50);

    // Same job with a 3-cycle stall between beats
    start_job(2, t0);
    send_beat({8'd3, 8'd1}, {8'd6, 8'd5}, 0);
    send_beat({8'd4, 8'd2}, {8'd8, 8'd7}, 3);
    wait_done(100, td);
    check("stall_latency", 64'(td - t0), 64'd15);
    check_c("stall", 19, 22, 43, 50);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    check("stall_count", 64'(stall_cnt), 64'd3);
`else
    check("stall_count", 64'(stall_cnt), 64'd0);
`endif

    // Skew timing of a single beat
    start_job(1, t0);
    send_beat({8'hAA, 8'h55}, {8'hAA, 8'h55}, 0);
    check("skew_l0", 64'(a_edge[7:0]), 64'h55);
    check("skew_l1_early", 64'(a_edge[15:8]), 64'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("skew_l1", 64'(a_edge[15:8]), 64'hAA);
    check("skew_b_l1", 64'(b_edge[15:8]), 64'hAA);
    check("skew_l0_zero", 64'(a_edge[7:0]), 64'h00);
    wait_done(100, td);
    check("skew_latency", 64'(td - t0), 64'd11);

    // Empty job
    start_job(0, t0);
    check("k0_clr", 64'(array_clr), 64'd1);
    check("k0_en", 64'(pe_en), 64'd0);
    wait_done(20, td);
    check("k0_latency", 64'(td - t0), 64'd2);

    // Oversized k_len clamps to K_MAX
    start_job(20, t0);
    for (int b = 0; b < K_MAX; b++) send_beat({8'd1, 8'd1}, {8'd1, 8'd1}, 0);
    wait_done(100, td);
    check("clamp_latency", 64'(td - t0), 64'd26);
    check_c("clamp", 16, 16, 16, 16);

    // Back-to-back K_MAX jobs with start and in_valid held high
    @(posedge clk); #1;
    k_len = KW'(K_MAX);
    start = 1'b1;
    op.in_valid = 1'b1;
    op.in_a = {8'd2, 8'd2};
    op.in_b = {8'd3, 8'd3};
    t0 = cyc;
    wait_done(200, td);
    check("b2b_first", 64'(td - t0), 64'd26);
    check_c("b2b1", 96, 96, 96, 96);
    wait_done(200, td2);
    start = 1'b0;
    op.in_valid = 1'b0;
    check("b2b_gap", 64'(td2 - td), 64'd27);
    check_c("b2b2", 96, 96, 96, 96);

    // Reset in the middle of FEED
    start_job(2, t0);
    send_beat({8'd9, 8'd7}, {8'd5, 8'd3}, 0);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid", 64'({op.in_ready, pe_en, array_clr, busy, done, a_edge, b_edge, stall_cnt}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nd = 0;
    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("rst_no_done", 64'(nd), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
